// File: rtl/systolic_array_ctrl_if.sv
// rtl/systolic_array_ctrl_if.sv - Vector handshake and cell-0 drive bundle for systolic_array_ctrl
//
// Signals
//   in_valid   upstream has a vector on x_in of cell 0
//   in_ready   controller accepts the vector this cycle
//   ce         clock enable to every cell in the chain
//   mem_addr   weight address into cell 0
//   ctrl_out   control word into cell 0 ctrl_in
//   out_valid  y_out of the last cell holds a valid result
// Modports
//   master  upstream/host side (drives in_valid, observes the rest)
//   slave   controller side
interface systolic_array_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      ce;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               ctrl_out;
    logic                      out_valid;

    modport master (
        output in_valid,
        input  in_ready, ce, mem_addr, ctrl_out, out_valid
    );

    modport slave (
        input  in_valid,
        output in_ready, ce, mem_addr, ctrl_out, out_valid
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - Job sequencer for a 1-D chain of systolic cells
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          job start, sampled in IDLE only
//   abort          synchronous abort, any state -> IDLE next cycle
//   num_vectors    vectors in the job, latched on accepted start
//   cif (slave)    in_valid/in_ready handshake, ce, mem_addr, ctrl_out, out_valid
//   busy           high in every state except IDLE
//   done           one-cycle pulse at end of job
//   stall_count    STREAM cycles with in_valid=0
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to build the stall counter;
// otherwise stall_count is tied to zero.
module systolic_array_ctrl #(
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int NUM_WEIGHTS    = 16,
    parameter int ROWS           = 4,
    parameter int PRIME_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           num_vectors,
    systolic_array_ctrl_if.slave  cif,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_count
);
    localparam int LATENCY = 2 * ROWS + 1;
    localparam int CNT_W   = $clog2(LATENCY + PRIME_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, FINISH} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [15:0]               num_q;
    logic [15:0]               vec_cnt_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               ctrl_q;
    logic                      out_valid_q;
    // LATENCY-1 stages here plus out_valid_q make up the full valid pipeline
    logic [LATENCY-2:0]        vpipe_q;

    logic in_ready_c, ce_c, xfer, is_last, is_first, accept_start;

    assign is_last      = (vec_cnt_q == num_q - 16'd1);
    assign is_first     = (vec_cnt_q == 16'd0);
    assign xfer         = in_ready_c & cif.in_valid;
    assign accept_start = (state_q == IDLE) & start & ~abort;

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        ce_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_vectors == 16'd0) ? FINISH : PRIME;
            end
            PRIME: begin
                ce_c = 1'b1;
                if (cnt_q == CNT_W'(PRIME_CYCLES - 1)) state_d = STREAM;
            end
            STREAM: begin
                in_ready_c = 1'b1;
                ce_c       = cif.in_valid;
                if (cif.in_valid && is_last) state_d = DRAIN;
            end
            DRAIN: begin
                ce_c = 1'b1;
                if (cnt_q == CNT_W'(LATENCY - 1)) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort gates the enables too, so nothing moves in the abort cycle
        if (abort) begin
            state_d    = IDLE;
            in_ready_c = 1'b0;
            ce_c       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            vec_cnt_q   <= '0;
            addr_q      <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            vpipe_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == FINISH);
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;

            if (accept_start) begin
                num_q     <= num_vectors;
                vec_cnt_q <= '0;
                addr_q    <= '0;
            end else if (xfer) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
                addr_q    <= (addr_q == MEM_ADDR_WIDTH'(NUM_WEIGHTS - 1)) ? '0 : addr_q + 1'b1;
            end

            // ctrl_out describes the transfer that happened on this edge
            ctrl_q <= {xfer ? vec_cnt_q : 16'd0, 12'd0, xfer, state_d == DRAIN,
                       xfer & is_last, xfer & is_first};

            // Results leave the chain only on enabled edges; a stalled cycle
            // produces no new result, hence the pulse is dropped when ce=0.
            if (ce_c) begin
                vpipe_q     <= {vpipe_q[LATENCY-3:0], xfer};
                out_valid_q <= vpipe_q[LATENCY-2];
            end else begin
                out_valid_q <= 1'b0;
            end

            if (abort) begin
                vpipe_q     <= '0;
                out_valid_q <= 1'b0;
                ctrl_q      <= '0;
                addr_q      <= '0;
                vec_cnt_q   <= '0;
            end
        end
    end

    assign cif.in_ready  = in_ready_c;
    assign cif.ce        = ce_c;
    assign cif.mem_addr  = addr_q;
    assign cif.ctrl_out  = ctrl_q;
    assign cif.out_valid = out_valid_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
        end else if (state_q == STREAM && !cif.in_valid && !abort) begin
            stall_q <= stall_q + 32'd1;
        end
    end
    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif
endmodule
